step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Tempo-driven 16-step pattern sequencer feeding the track playback control stage.
//  Owns the 16-bit step pattern (track_vec) and the current step index (track_iter).
//  Advances the step at BPM*STEPS_PER_BEAT/60 Hz using a divider-free phase accumulator.
//  Also handles play/pause/stop, BPM adjust and cursor-based pattern editing from debounced pulses.
// PARAMETERS
//  CLK_HZ        100_000_000  clk frequency in Hz
//  STEPS_PER_BEAT 4           steps per beat (16th notes)
//  BPM_MIN       60           lowest BPM; saturating bound
//  BPM_MAX       240          highest BPM; saturating bound
//  BPM_DEFAULT   120          BPM after reset
//  BPM_STEP      4            BPM change per bpm_up/bpm_down pulse
//  PATTERN_INIT  16'h8888     track_vec value after reset
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  play_btn     in   1   1-cycle pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//  stop_btn     in   1   1-cycle pulse: any state -> IDLE, step to 0
//  bpm_up       in   1   1-cycle pulse: bpm += BPM_STEP, saturating
//  bpm_down     in   1   1-cycle pulse: bpm -= BPM_STEP, saturating
//  cursor_left  in   1   1-cycle pulse: cursor - 1, mod 16
//  cursor_right in   1   1-cycle pulse: cursor + 1, mod 16
//  toggle_btn   in   1   1-cycle pulse: track_vec[cursor] ^= 1
//  clear_btn    in   1   1-cycle pulse: track_vec <= 0
//  track_vec    out  16  step pattern; bit i = play on step i
//  track_iter   out  4   current step index
//  step_tick    out  1   1-cycle pulse on the cycle track_iter takes a new step
//  running      out  1   1 while state == RUN
//  bpm          out  8   current tempo
//  cursor       out  4   edit cursor position
// BEHAVIOUR
//  All inputs are synchronous to clk and arrive as 1-cycle pulses from the debounce stage.
//  All outputs are registered.
//  Reset: state=IDLE, track_iter=0, acc=0, step_tick=0, running=0, bpm=BPM_DEFAULT, cursor=0,
//   track_vec=PATTERN_INIT.
//  Reset deasserted mid-run behaves exactly like a power-on reset; no state survives it.
//  FSM states IDLE, RUN, PAUSE:
//   - IDLE + play: ->RUN; track_iter=0, acc=0, step_tick=1 on the entry edge (step 0 sounds).
//   - RUN + play: ->PAUSE; track_iter and acc held.
//   - PAUSE + play: ->RUN; no tick on resume; acc continues from its held value.
//   - stop in any state: ->IDLE, track_iter=0, acc=0. stop wins over a same-cycle play.
//  Accumulator: LIMIT = 60*CLK_HZ, INC = bpm*STEPS_PER_BEAT; acc is 34 bits, no overflow at defaults.
//   - In RUN each cycle: s = acc + INC.
//     If s >= LIMIT: acc = s - LIMIT, track_iter+1 (15 wraps to 0), step_tick=1 on the same edge.
//     Otherwise: acc = s, step_tick = 0.
//   - acc is not updated in IDLE or PAUSE; step_tick = 0 there except on the IDLE->RUN entry edge.
//  BPM: up/down saturate at BPM_MAX/BPM_MIN; both asserted in one cycle = no change.
//   A new bpm is used for INC from the next cycle; acc is not cleared on a BPM change.
//  Cursor: left/right wrap mod 16; both asserted in one cycle = no change.
//  Edit: toggle acts on the pre-move cursor when a move arrives in the same cycle.
//   clear overrides a same-cycle toggle. Edits are allowed in every state.
//   An edit to the step currently playing is visible downstream on the next cycle.
// TESTING (sim with CLK_HZ=1000 -> LIMIT=60000)
//  1. Reset asserted mid-RUN -> all outputs at reset values next cycle; running=0, track_vec=16'h8888.
//  2. play at bpm 120 (INC=480) -> step_tick on entry with iter=0, then every 125 cycles;
//     iter reaches 15, then wraps to 0 at cycle 2000.
//  3. play again when iter=3, hold 500 cycles -> iter stays 3, no ticks;
//     play again -> next tick after the remaining (60000-acc)/480 cycles.
//  4. 40 bpm_up pulses from 120 -> bpm saturates at 240; tick intervals alternate 62/63 cycles.
//     bpm_up and bpm_down together -> bpm unchanged.
//  5. cursor_left from 0 -> cursor=15; toggle -> bit15 flips.
//     toggle+cursor_right same cycle at cursor 15 -> bit15 flips, cursor=0.
//     clear+toggle same cycle -> track_vec=0.
//  6. stop+play same cycle in RUN at iter=9 -> IDLE, iter=0, running=0, no step_tick.

Source files
------------

// File: rtl/step_sequencer_if.sv
// rtl/step_sequencer_if.sv - control pulses in, pattern/step/tempo state out
interface step_sequencer_if;
  logic        play_btn;
  logic        stop_btn;
  logic        bpm_up;
  logic        bpm_down;
  logic        cursor_left;
  logic        cursor_right;
  logic        toggle_btn;
  logic        clear_btn;
  logic [15:0] track_vec;
  logic [3:0]  track_iter;
  logic        step_tick;
  logic        running;
  logic [7:0]  bpm;
  logic [3:0]  cursor;

  modport master (
    output play_btn, stop_btn, bpm_up, bpm_down,
    output cursor_left, cursor_right, toggle_btn, clear_btn,
    input  track_vec, track_iter, step_tick, running, bpm, cursor
  );

  modport slave (
    input  play_btn, stop_btn, bpm_up, bpm_down,
    input  cursor_left, cursor_right, toggle_btn, clear_btn,
    output track_vec, track_iter, step_tick, running, bpm, cursor
  );
endinterface

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - tempo-driven 16-step pattern sequencer
module step_sequencer #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned STEPS_PER_BEAT = 4,
  parameter int unsigned BPM_MIN        = 60,
  parameter int unsigned BPM_MAX        = 240,
  parameter int unsigned BPM_DEFAULT    = 120,
  parameter int unsigned BPM_STEP       = 4,
  parameter logic [15:0] PATTERN_INIT   = 16'h8888
) (
  input  logic             clk,
  input  logic             reset,
  step_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  // One step is due each time acc crosses 60*CLK_HZ while adding bpm*STEPS_PER_BEAT per cycle.
  localparam logic [33:0] LIMIT = 34'(64'(CLK_HZ) * 64'd60);
  localparam logic [8:0]  MAX9  = 9'(BPM_MAX);
  localparam logic [8:0]  MIN9  = 9'(BPM_MIN);
  localparam logic [8:0]  STEP9 = 9'(BPM_STEP);

  state_t      state_q, state_d;
  logic [33:0] acc_q, acc_d;
  logic [3:0]  iter_q, iter_d;
  logic        tick_q, tick_d;
  logic        running_q, running_d;
  logic [7:0]  bpm_q, bpm_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [15:0] vec_q, vec_d;
  logic [33:0] inc, sum;
  logic [8:0]  bpm_w;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    tick_d   = 1'b0;
    bpm_d    = bpm_q;
    cursor_d = cursor_q;
    vec_d    = vec_q;
    inc      = 34'(bpm_q) * 34'(STEPS_PER_BEAT);
    sum      = acc_q + inc;
    bpm_w    = {1'b0, bpm_q};

    if (bus.stop_btn) begin
      state_d = IDLE;
      acc_d   = '0;
      iter_d  = '0;
    end else if (bus.play_btn) begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          acc_d   = '0;
          iter_d  = '0;
          tick_d  = 1'b1;
        end
        RUN:     state_d = PAUSE;
        default: state_d = RUN;
      endcase
    end else if (state_q == RUN) begin
      if (sum >= LIMIT) begin
        acc_d  = sum - LIMIT;
        iter_d = iter_q + 4'd1;
        tick_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    running_d = (state_d == RUN);

    if (bus.bpm_up && !bus.bpm_down) begin
      bpm_d = (bpm_w + STEP9 > MAX9) ? 8'(MAX9) : 8'(bpm_w + STEP9);
    end else if (bus.bpm_down && !bus.bpm_up) begin
      bpm_d = (bpm_w < MIN9 + STEP9) ? 8'(MIN9) : 8'(bpm_w - STEP9);
    end

    // Toggle uses the cursor as it stood before any same-cycle move.
    if (bus.clear_btn) begin
      vec_d = '0;
    end else if (bus.toggle_btn) begin
      vec_d = vec_q ^ (16'h0001 << cursor_q);
    end

    if (bus.cursor_left && !bus.cursor_right) begin
      cursor_d = cursor_q - 4'd1;
    end else if (bus.cursor_right && !bus.cursor_left) begin
      cursor_d = cursor_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      iter_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      bpm_q     <= 8'(BPM_DEFAULT);
      cursor_q  <= '0;
      vec_q     <= PATTERN_INIT;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      iter_q    <= iter_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      bpm_q     <= bpm_d;
      cursor_q  <= cursor_d;
      vec_q     <= vec_d;
    end
  end

  assign bus.track_vec  = vec_q;
  assign bus.track_iter = iter_q;
  assign bus.step_tick  = tick_q;
  assign bus.running    = running_q;
  assign bus.bpm        = bpm_q;
  assign bus.cursor     = cursor_q;
endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer
module tb_step_sequencer;
  localparam logic [7:0] PLAY = 8'h01, STOP = 8'h02, UP = 8'h04, DOWN = 8'h08;
  localparam logic [7:0] LEFT = 8'h10, RIGHT = 8'h20, TOG = 8'h40, CLR = 8'h80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  step_sequencer_if sif();
  step_sequencer #(.CLK_HZ(1000)) dut (.clk(clk), .reset(reset), .bus(sif.slave));

  int total = 0;
  int bad = 0;

  // Reference model: tempo as a running sum compared against one step's worth of work.
  int          m_state;  // 0 idle, 1 run, 2 pause
  longint      m_acc;
  int          m_iter;
  bit          m_tick;
  int          m_bpm;
  int          m_cur;
  logic [15:0] m_vec;

  typedef struct {
    logic [7:0]  b;
    logic [3:0]  cur;
    logic [15:0] vec;
    logic [7:0]  bpm;
    logic        run;
    logic        tick;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_iter = 0; m_tick = 0;
    m_bpm = 120; m_cur = 0; m_vec = 16'h8888;
  endtask

  task automatic model_step(input logic [7:0] b);
    m_tick = 0;
    if (b[1]) begin
      m_state = 0; m_acc = 0; m_iter = 0;
    end else if (b[0]) begin
      if (m_state == 0) begin
        m_state = 1; m_acc = 0; m_iter = 0; m_tick = 1;
      end else m_state = (m_state == 1) ? 2 : 1;
    end else if (m_state == 1) begin
      m_acc += m_bpm * 4;
      if (m_acc >= 60000) begin
        m_acc -= 60000; m_iter = (m_iter + 1) % 16; m_tick = 1;
      end
    end
    if (b[2] && !b[3]) m_bpm = (m_bpm + 4 > 240) ? 240 : m_bpm + 4;
    if (b[3] && !b[2]) m_bpm = (m_bpm - 4 < 60) ? 60 : m_bpm - 4;
    if (b[7]) m_vec = 16'h0;
    else if (b[6]) m_vec[m_cur] = ~m_vec[m_cur];
    if (b[4] && !b[5]) m_cur = (m_cur + 15) % 16;
    if (b[5] && !b[4]) m_cur = (m_cur + 1) % 16;
  endtask

  task automatic drive(input logic [7:0] b);
    sif.play_btn = b[0];    sif.stop_btn = b[1];
    sif.bpm_up = b[2];      sif.bpm_down = b[3];
    sif.cursor_left = b[4]; sif.cursor_right = b[5];
    sif.toggle_btn = b[6];  sif.clear_btn = b[7];
  endtask

  task automatic cycle(input logic [7:0] b);
    drive(b);
    model_step(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("rnd_vec", sif.track_vec, m_vec);
    chk("rnd_iter", sif.track_iter, m_iter);
    chk("rnd_tick", sif.step_tick, m_tick);
    chk("rnd_running", sif.running, m_state == 1);
    chk("rnd_bpm", sif.bpm, m_bpm);
    chk("rnd_cursor", sif.cursor, m_cur);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vec"}, sif.track_vec, 16'h8888);
    chk({tag, "_iter"}, sif.track_iter, 0);
    chk({tag, "_tick"}, sif.step_tick, 0);
    chk({tag, "_running"}, sif.running, 0);
    chk({tag, "_bpm"}, sif.bpm, 120);
    chk({tag, "_cursor"}, sif.cursor, 0);
  endtask

  task automatic do_reset(input string tag);
    drive(8'h00);
    #2 reset = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advances idle cycles until the next step_tick; returns cycles taken (0 on timeout).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle(8'h00);
      n++;
    end while (!sif.step_tick && n < 400);
    if (!sif.step_tick) n = 0;
  endtask

  task automatic wait_iter(input int target);
    int n = 0;
    while (sif.track_iter != 4'(target) && n < 3000) begin
      cycle(8'h00);
      n++;
    end
    chk("wait_iter", sif.track_iter, target);
  endtask

  initial begin
    int n, n1, n2, n3, n4, ticks;
    drive(8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    tbl[0]  = '{LEFT,        4'd15, 16'h8888, 8'd120, 1'b0, 1'b0};
    tbl[1]  = '{TOG,         4'd15, 16'h0888, 8'd120, 1'b0, 1'b0};
    tbl[2]  = '{TOG | RIGHT, 4'd0,  16'h8888, 8'd120, 1'b0, 1'b0};
    tbl[3]  = '{TOG,         4'd0,  16'h8889, 8'd120, 1'b0, 1'b0};
    tbl[4]  = '{UP | DOWN,   4'd0,  16'h8889, 8'd120, 1'b0, 1'b0};
    tbl[5]  = '{UP,          4'd0,  16'h8889, 8'd124, 1'b0, 1'b0};
    tbl[6]  = '{DOWN,        4'd0,  16'h8889, 8'd120, 1'b0, 1'b0};
    tbl[7]  = '{DOWN,        4'd0,  16'h8889, 8'd116, 1'b0, 1'b0};
    tbl[8]  = '{CLR | TOG,   4'd0,  16'h0000, 8'd116, 1'b0, 1'b0};
    tbl[9]  = '{RIGHT | LEFT,4'd0,  16'h0000, 8'd116, 1'b0, 1'b0};
    tbl[10] = '{RIGHT,       4'd1,  16'h0000, 8'd116, 1'b0, 1'b0};
    tbl[11] = '{TOG,         4'd1,  16'h0002, 8'd116, 1'b0, 1'b0};
    tbl[12] = '{PLAY,        4'd1,  16'h0002, 8'd116, 1'b1, 1'b1};
    tbl[13] = '{PLAY,        4'd1,  16'h0002, 8'd116, 1'b0, 1'b0};
    tbl[14] = '{STOP,        4'd1,  16'h0002, 8'd116, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].b);
      chk($sformatf("tbl%0d_cursor", i), sif.cursor, tbl[i].cur);
      chk($sformatf("tbl%0d_vec", i), sif.track_vec, tbl[i].vec);
      chk($sformatf("tbl%0d_bpm", i), sif.bpm, tbl[i].bpm);
      chk($sformatf("tbl%0d_running", i), sif.running, tbl[i].run);
      chk($sformatf("tbl%0d_tick", i), sif.step_tick, tbl[i].tick);
      chk($sformatf("tbl%0d_iter", i), sif.track_iter, 0);
    end
    cycle(8'h00);

    // Steady tempo at 120 bpm: one step every 125 cycles, a full bar in 2000.
    do_reset("rst_idle");
    cycle(PLAY);
    chk("entry_tick", sif.step_tick, 1);
    chk("entry_iter", sif.track_iter, 0);
    chk("entry_running", sif.running, 1);
    for (int k = 1; k <= 16; k++) begin
      wait_tick(n);
      chk($sformatf("interval120_%0d", k), n, 125);
      chk($sformatf("iter120_%0d", k), sif.track_iter, k % 16);
    end

    // Pause keeps the step and phase; resume finishes the remaining phase.
    wait_iter(3);
    repeat (37) cycle(8'h00);
    cycle(PLAY);
    chk("pause_running", sif.running, 0);
    ticks = 0;
    for (int i = 0; i < 500; i++) begin
      cycle(8'h00);
      if (sif.step_tick) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    chk("pause_iter", sif.track_iter, 3);
    cycle(PLAY);
    chk("resume_tick", sif.step_tick, 0);
    chk("resume_running", sif.running, 1);
    wait_tick(n);
    chk("resume_remaining", n, 88);
    chk("resume_iter", sif.track_iter, 4);

    // Tempo saturation and the 62/63 cadence at 240 bpm.
    repeat (40) cycle(UP);
    chk("bpm_sat_max", sif.bpm, 240);
    wait_tick(n);
    wait_tick(n1); wait_tick(n2); wait_tick(n3); wait_tick(n4);
    chk("i240_a", (n1 == 62 || n1 == 63), 1);
    chk("i240_pair1", n1 + n2, 125);
    chk("i240_alt", n1 != n2, 1);
    chk("i240_pair2", n3 + n4, 125);
    cycle(UP | DOWN);
    chk("bpm_both_240", sif.bpm, 240);
    cycle(DOWN);
    chk("bpm_down_236", sif.bpm, 236);
    repeat (50) cycle(DOWN);
    chk("bpm_sat_min", sif.bpm, 60);

    // Stop beats a same-cycle play.
    repeat (40) cycle(UP);
    wait_iter(9);
    cycle(STOP | PLAY);
    chk("stop_running", sif.running, 0);
    chk("stop_iter", sif.track_iter, 0);
    chk("stop_tick", sif.step_tick, 0);
    repeat (200) cycle(8'h00);
    chk("idle_hold_iter", sif.track_iter, 0);

    // Reset in the middle of a run clears everything, including edits.
    cycle(PLAY);
    cycle(CLR | RIGHT | DOWN);
    repeat (300) cycle(8'h00);
    do_reset("rst_run");
    cycle(8'h00);
    check_reset_outputs("post_rst");

    // Random pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      b = 8'h00;
      b[0] = ($urandom_range(0, 63) == 0);
      b[1] = ($urandom_range(0, 255) == 0);
      for (int j = 2; j < 8; j++) b[j] = ($urandom_range(0, 15) == 0);
      b[7] = b[7] & ($urandom_range(0, 3) == 0);
      cycle(b);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
